// File: rtl/row_package_feeder_pkg.sv
// Shared defaults and FSM state encoding for the row package feeder.
// Used by row_package_feeder and feeder_addr_gen.
package row_package_feeder_pkg;

    localparam int ELEMENT_WIDTH = 32;
    localparam int NO_OF_UNITS   = 8;
    localparam int ADDR_WIDTH    = 13;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_ROW_START = 3'd1;
    localparam state_t S_FETCH     = 3'd2;
    localparam state_t S_ISSUE     = 3'd3;
    localparam state_t S_GAP       = 3'd4;
    localparam state_t S_DRAIN     = 3'd5;
    localparam state_t S_DONE      = 3'd6;

endpackage

// File: rtl/row_package_feeder_addr_gen.sv
// Address generator: latched bases, package index, modulo adders.
// Addresses wrap naturally at 2^addr_width.
module feeder_addr_gen
    import row_package_feeder_pkg::*;
#(
    parameter int addr_width = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  adv_i,
    input  logic [addr_width-1:0] row_base_i,
    input  logic [addr_width-1:0] vec_base_i,
    output logic [addr_width-1:0] mat_addr_o,
    output logic [addr_width-1:0] vec_addr_o,
    output logic [31:0]           pkg_idx_o
);

    logic [addr_width-1:0] row_base_q;
    logic [addr_width-1:0] vec_base_q;
    logic [31:0]           idx_q;

    // Latch bases at row start, then step the index once per issued package.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            row_base_q <= '0;
            vec_base_q <= '0;
            idx_q      <= '0;
        end else if (load_i) begin
            row_base_q <= row_base_i;
            vec_base_q <= vec_base_i;
            idx_q      <= '0;
        end else if (adv_i) begin
            idx_q <= idx_q + 32'd1;
        end
    end

    assign mat_addr_o = row_base_q + idx_q[addr_width-1:0];
    assign vec_addr_o = vec_base_q + idx_q[addr_width-1:0];
    assign pkg_idx_o  = idx_q;

endmodule

// File: rtl/row_package_feeder.sv
// Streams one matrix/vector row pair as packages to the dot-product stage.
// ROW_FEEDER_PERF_CNT_EN adds pkt_count / stall_count outputs.
module row_package_feeder
    import row_package_feeder_pkg::*;
#(
    parameter int no_of_units   = NO_OF_UNITS,
    parameter int element_width = ELEMENT_WIDTH,
    parameter int addr_width    = ADDR_WIDTH,
    parameter int issue_gap     = 4
) (
    input  logic                                 clk,
    input  logic                                 main_reset,
    input  logic                                 start,
    input  logic [addr_width-1:0]                row_base_addr,
    input  logic [addr_width-1:0]                vec_base_addr,
    input  logic [31:0]                          row_length,
    output logic [addr_width-1:0]                mat_addr,
    output logic [addr_width-1:0]                vec_addr,
    input  logic [element_width*no_of_units-1:0] mat_data,
    input  logic [element_width*no_of_units-1:0] vec_data,
    output logic                                 reset,
    output logic [31:0]                          no_of_multiples,
    output logic [element_width*no_of_units-1:0] first_row_input,
    output logic [element_width*no_of_units-1:0] second_row_input,
    output logic                                 outsider_read_now,
    input  logic                                 prepare_my_new_input,
    output logic                                 busy,
`ifdef ROW_FEEDER_PERF_CNT_EN
    output logic [31:0]                          pkt_count,
    output logic [31:0]                          stall_count,
`endif
    output logic                                 done
);

    localparam int PW = element_width * no_of_units;
    localparam int GW = $clog2(issue_gap + 1);

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [31:0]     len_q;
    logic [31:0]     pkg_idx;
    logic [PW-1:0]   first_q, second_q;
    logic            strobe_q;
    logic            done_q;
    logic            accept;
    logic            zero_req;
    logic            last_pkg;

    assign accept   = (state_q == S_IDLE) && start && (row_length != 32'd0);
    assign zero_req = (state_q == S_IDLE) && start && (row_length == 32'd0);
    assign last_pkg = (pkg_idx == len_q - 32'd1);

    feeder_addr_gen #(
        .addr_width (addr_width)
    ) u_addr_gen (
        .clk        (clk),
        .rst_i      (main_reset),
        .load_i     (accept),
        .adv_i      (state_q == S_ISSUE),
        .row_base_i (row_base_addr),
        .vec_base_i (vec_base_addr),
        .mat_addr_o (mat_addr),
        .vec_addr_o (vec_addr),
        .pkg_idx_o  (pkg_idx)
    );

    // Next-state logic; GAP pads each issue period out to issue_gap cycles.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_ROW_START;
            S_ROW_START: state_d = S_FETCH;
            S_FETCH:     state_d = S_ISSUE;
            S_ISSUE: begin
                if (last_pkg) begin
                    state_d = S_DRAIN;
                end else if (issue_gap > 2) begin
                    state_d = S_GAP;
                    gap_d   = GW'(issue_gap - 3);
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_FETCH;
                else             gap_d   = gap_q - GW'(1);
            end
            S_DRAIN:     if (prepare_my_new_input) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State, row length latch, package registers and pulse outputs.
    always_ff @(posedge clk or posedge main_reset) begin
        if (main_reset) begin
            state_q  <= S_IDLE;
            gap_q    <= '0;
            len_q    <= '0;
            first_q  <= '0;
            second_q <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            strobe_q <= (state_q == S_ISSUE);
            done_q   <= zero_req ||
                        ((state_q == S_DRAIN) && prepare_my_new_input);
            if (accept) len_q <= row_length;
            if (state_q == S_ISSUE) begin
                first_q  <= mat_data;
                second_q <= vec_data;
            end
        end
    end

    assign reset             = (state_q == S_ROW_START);
    assign no_of_multiples   = reset ? len_q : 32'd0;
    assign first_row_input   = first_q;
    assign second_row_input  = second_q;
    assign outsider_read_now = strobe_q;
    assign busy              = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done              = done_q;

`ifdef ROW_FEEDER_PERF_CNT_EN
    logic [31:0] pkt_q, stall_q;

    // Saturating activity counters; only main_reset clears them.
    always_ff @(posedge clk or posedge main_reset) begin
        if (main_reset) begin
            pkt_q   <= '0;
            stall_q <= '0;
        end else begin
            if (strobe_q && (pkt_q != '1))
                pkt_q <= pkt_q + 32'd1;
            if ((state_q == S_DRAIN) && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
        end
    end

    assign pkt_count   = pkt_q;
    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_row_package_feeder.sv
// Scoreboard bench for row_package_feeder (default parameters).
// Expected packages are queued at start and checked at each strobe.
module tb_row_package_feeder;
    import row_package_feeder_pkg::*;

    localparam int AW = 13;
    localparam int PW = 256;

    typedef struct {
        int            fetch_cyc;
        int            strobe_cyc;
        logic [AW-1:0] ma;
        logic [AW-1:0] va;
        logic [PW-1:0] md;
        logic [PW-1:0] vd;
    } pkt_t;

    logic          clk = 0;
    logic          main_reset = 1;
    logic          start = 0;
    logic [AW-1:0] row_base_addr = '0;
    logic [AW-1:0] vec_base_addr = '0;
    logic [31:0]   row_length = '0;
    logic [AW-1:0] mat_addr, vec_addr;
    logic [PW-1:0] mat_data = '0, vec_data = '0;
    logic          reset;
    logic [31:0]   no_of_multiples;
    logic [PW-1:0] first_row_input, second_row_input;
    logic          outsider_read_now;
    logic          prepare_my_new_input = 0;
    logic          busy, done;

    int   tests = 0, fails = 0;
    int   cyc = 0;
    int   exp_rst_cyc = -1;
    int   exp_nom = 0;
    int   done_cnt = 0;
    pkt_t q[$];

    row_package_feeder dut (
        .clk                  (clk),
        .main_reset           (main_reset),
        .start                (start),
        .row_base_addr        (row_base_addr),
        .vec_base_addr        (vec_base_addr),
        .row_length           (row_length),
        .mat_addr             (mat_addr),
        .vec_addr             (vec_addr),
        .mat_data             (mat_data),
        .vec_data             (vec_data),
        .reset                (reset),
        .no_of_multiples      (no_of_multiples),
        .first_row_input      (first_row_input),
        .second_row_input     (second_row_input),
        .outsider_read_now    (outsider_read_now),
        .prepare_my_new_input (prepare_my_new_input),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] pat(logic [AW-1:0] a, logic [15:0] s);
        logic [PW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = {3'(i), a, s};
        return r;
    endfunction

    // Synchronous memories: data one cycle after the address.
    always @(posedge clk) begin
        mat_data <= pat(mat_addr, 16'h1A1A);
        vec_data <= pat(vec_addr, 16'hC3C3);
    end

    task automatic chk(string tag, logic [PW-1:0] got, logic [PW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: reset pulse timing, address at fetch, package at strobe.
    always @(negedge clk) begin
        if (!main_reset) begin
            if (reset) begin
                chk("rst_cyc", PW'(cyc), PW'(exp_rst_cyc));
                chk("nom", PW'(no_of_multiples), PW'(exp_nom));
            end
            if (q.size() != 0 && cyc == q[0].fetch_cyc) begin
                chk("mat_addr", PW'(mat_addr), PW'(q[0].ma));
                chk("vec_addr", PW'(vec_addr), PW'(q[0].va));
            end
            if (outsider_read_now) begin
                if (q.size() == 0) begin
                    chk("unexp_strobe", 1, 0);
                end else begin
                    pkt_t e;
                    e = q.pop_front();
                    chk("strobe_cyc", PW'(cyc), PW'(e.strobe_cyc));
                    chk("first_row", first_row_input, e.md);
                    chk("second_row", second_row_input, e.vd);
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic launch(input logic [AW-1:0] rb, input logic [AW-1:0] vb,
                          input int len, output int s);
        @(negedge clk);
        row_base_addr = rb;
        vec_base_addr = vb;
        row_length    = len;
        start         = 1;
        s             = cyc + 1;
        exp_rst_cyc   = (len != 0) ? s : -1;
        exp_nom       = len;
        for (int k = 0; k < len; k++) begin
            pkt_t e;
            e.fetch_cyc  = s + 1 + 4 * k;
            e.strobe_cyc = s + 3 + 4 * k;
            e.ma         = rb + AW'(k);
            e.va         = vb + AW'(k);
            e.md         = pat(e.ma, 16'h1A1A);
            e.vd         = pat(e.va, 16'hC3C3);
            q.push_back(e);
        end
    endtask

    task automatic run_row(input logic [AW-1:0] rb, input logic [AW-1:0] vb,
                           input int len, input int pdly, input bit inj);
        int s;
        int budget;
        int busy_low;
        launch(rb, vb, len, s);
        budget = 0;
        do begin
            @(negedge clk);
            if (inj && cyc == s + 2) begin
                start         = 1;
                row_length    = 7;
                row_base_addr = 13'h0AAA;
                vec_base_addr = 13'h0555;
            end else begin
                start = 0;
            end
            budget++;
        end while (q.size() != 0 && budget < 200);
        start = 0;
        if (budget >= 200) chk("timeout", 0, 1);
        busy_low = 0;
        for (int i = 0; i < pdly; i++) begin
            @(negedge clk);
            if (!busy || done) busy_low++;
        end
        chk("busy_in_drain", PW'(busy_low), 0);
        prepare_my_new_input = 1;
        @(negedge clk);
        prepare_my_new_input = 0;
        chk("done_pulse", PW'(done), 1);
        chk("busy_at_done", PW'(busy), 0);
        @(negedge clk);
        chk("done_low", PW'(done), 0);
    endtask

    initial begin
        int s;
        int seen;
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_busy", PW'(busy), 0);
        chk("rst_done", PW'(done), 0);
        chk("rst_strobe", PW'(outsider_read_now), 0);
        chk("rst_first", first_row_input, 0);
        chk("rst_maddr", PW'(mat_addr), 0);
        main_reset = 0;

        // Basic 3-package row.
        run_row(13'h010, 13'h200, 3, 0, 0);
        // Late prepare: busy must hold through DRAIN.
        run_row(13'h040, 13'h300, 2, 20, 0);

        // Zero-length row: immediate done, nothing else.
        launch(13'h077, 13'h088, 0, s);
        @(negedge clk);
        start = 0;
        chk("zero_done", PW'(done), 1);
        chk("zero_busy", PW'(busy), 0);
        @(negedge clk);
        chk("zero_done_low", PW'(done), 0);
        chk("zero_busy2", PW'(busy), 0);

        // Address wrap past all-ones.
        run_row(13'h1FFF, 13'h1FFE, 2, 1, 0);
        // Start during ISSUE must be ignored.
        run_row(13'h100, 13'h180, 3, 0, 1);

        // Abort mid-GAP of a 5-package row.
        launch(13'h020, 13'h220, 5, s);
        @(negedge clk);
        start = 0;
        while (cyc < s + 4) @(negedge clk);
        seen = done_cnt;
        main_reset = 1;
        #1;
        chk("abort_strobe", PW'(outsider_read_now), 0);
        chk("abort_first", first_row_input, 0);
        chk("abort_second", second_row_input, 0);
        chk("abort_busy", PW'(busy), 0);
        chk("abort_maddr", PW'(mat_addr), 0);
        chk("abort_vaddr", PW'(vec_addr), 0);
        q.delete();
        repeat (3) @(negedge clk);
        chk("abort_no_done", PW'(done_cnt), PW'(seen));
        main_reset = 0;
        run_row(13'h555, 13'h666, 1, 2, 0);

        repeat (3) @(negedge clk);
        chk("done_total", PW'(done_cnt), 6);
        chk("queue_empty", PW'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
